// File: rtl/tb_vp_pkg.sv
// Shared definitions for the testbench virtual peripheral:
// register offsets, magic status values and the register decoder.
package tb_vp_pkg;

  localparam logic [4:0] OFF_PRINT    = 5'h00;
  localparam logic [4:0] OFF_STATUS   = 5'h04;
  localparam logic [4:0] OFF_EXIT     = 5'h08;
  localparam logic [4:0] OFF_CYCLES   = 5'h0C;
  localparam logic [4:0] OFF_FIFOSTAT = 5'h10;

  localparam logic [31:0] TEST_PASS_MAGIC = 32'd123456789;
  localparam logic [31:0] TEST_FAIL_MAGIC = 32'd1;

  typedef enum logic [2:0] {
    REG_PRINT,
    REG_STATUS,
    REG_EXIT,
    REG_CYCLES,
    REG_FIFOSTAT,
    REG_NONE
  } reg_e;

  function automatic reg_e decode_reg(input logic [4:0] off);
    reg_e r;
    r = REG_NONE;
    unique case (1'b1)
      (off == OFF_PRINT):    r = REG_PRINT;
      (off == OFF_STATUS):   r = REG_STATUS;
      (off == OFF_EXIT):     r = REG_EXIT;
      (off == OFF_CYCLES):   r = REG_CYCLES;
      (off == OFF_FIFOSTAT): r = REG_FIFOSTAT;
      default:               r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tb_virtual_periph_if.sv
// OBI-style data bus between the core (master) and the
// virtual peripheral (slave).
interface tb_virtual_periph_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/tb_vp_char_fifo.sv
// First-word fall-through character FIFO for the stdout stream.
// Head data reads as zero while empty.
module tb_vp_char_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tb_virtual_periph.sv
// Memory-mapped testbench peripheral: stdout FIFO, pass/fail
// flags, exit code capture and a free-running cycle counter.
module tb_virtual_periph
  import tb_vp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  tb_virtual_periph_if.slave  bus,
  output logic                char_valid_o,
  output logic [7:0]          char_o,
  input  logic                char_ready_i,
  output logic                tests_passed_o,
  output logic                tests_failed_o,
  output logic                exit_valid_o,
  output logic [31:0]         exit_value_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  reg_e          w_reg;
  logic          w_sel;
  logic          w_wr;
  logic          w_rd;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_rdata;
  logic          w_unused;

  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic [31:0]   r_cycles;
  logic          r_passed;
  logic          r_failed;
  logic          r_exit;
  logic [31:0]   r_exit_value;

  assign w_sel = bus.req
              && (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign w_reg = decode_reg(bus.addr[4:0]);

  // Stall only a PRINT into a full FIFO; a same-cycle
  // pop does not make room for it.
  assign bus.gnt = rst_ni && w_sel
                && !(bus.we && w_reg == REG_PRINT && w_full);

  assign w_wr   = bus.gnt && bus.we;
  assign w_rd   = bus.gnt && !bus.we;
  assign w_push = w_wr && (w_reg == REG_PRINT) && bus.be[0];
  assign w_pop  = char_valid_o && char_ready_i;

  assign char_valid_o = !w_empty;
  assign w_unused     = ^bus.be[3:1];

  tb_vp_char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_data  (bus.wdata[7:0]),
    .i_pop   (w_pop),
    .o_data  (char_o),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      (w_reg == REG_CYCLES):   w_rdata = r_cycles;
      (w_reg == REG_FIFOSTAT): w_rdata = {w_full, 15'd0,
                                          16'(w_count)};
      default:                 w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_cycles     <= '0;
      r_passed     <= 1'b0;
      r_failed     <= 1'b0;
      r_exit       <= 1'b0;
      r_exit_value <= '0;
    end else begin
      r_rvalid <= bus.gnt;
      r_rdata  <= w_rd ? w_rdata : '0;
      r_cycles <= r_cycles + 32'd1;
      if (w_wr && w_reg == REG_STATUS) begin
        if (bus.wdata == TEST_PASS_MAGIC) r_passed <= 1'b1;
        if (bus.wdata == TEST_FAIL_MAGIC) r_failed <= 1'b1;
      end
      if (w_wr && w_reg == REG_EXIT) begin
        r_exit       <= 1'b1;
        r_exit_value <= bus.wdata;
      end
    end
  end

  assign bus.rvalid     = r_rvalid;
  assign bus.rdata      = r_rdata;
  assign tests_passed_o = r_passed;
  assign tests_failed_o = r_failed;
  assign exit_valid_o   = r_exit;
  assign exit_value_o   = r_exit_value;

endmodule

// File: tb/tb_tb_virtual_periph.sv
// Self-checking bench for tb_virtual_periph: register table
// plus directed FIFO, counter and reset sequences.
module tb_tb_virtual_periph;
  import tb_vp_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        char_valid_o;
  logic [7:0]  char_o;
  logic        char_ready_i = 1'b0;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;

  int checks = 0;
  int errors = 0;

  tb_virtual_periph_if bus ();

  tb_virtual_periph #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .bus            (bus),
    .char_valid_o   (char_valid_o),
    .char_o         (char_o),
    .char_ready_i   (char_ready_i),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  off;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_pass;
    logic        exp_fail;
    logic        exp_exit;
    logic [31:0] exp_exit_val;
    logic [7:0]  exp_char;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the
  // grant edge, with rvalid checked and req dropped.
  task automatic bus_txn(input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d,
                         output logic [31:0] rd);
    int n;
    n = 0;
    bus.req = 1'b1;
    bus.addr = a;
    bus.we = w;
    bus.be = b;
    bus.wdata = d;
    #1;
    while (!bus.gnt && n < 20) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (!bus.gnt) begin
      chk("gnt_timeout", 32'(bus.gnt), 32'd1);
      bus.req = 1'b0;
      rd = '0;
      return;
    end
    @(negedge clk_i);
    bus.req = 1'b0;
    rd = bus.rdata;
    chk("rvalid", 32'(bus.rvalid), 32'd1);
  endtask

  task automatic do_reset();
    bus.req = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  logic [31:0] rd;
  logic [31:0] c1;
  logic [31:0] c2;

  initial begin
    bus.req = 1'b0;
    bus.addr = '0;
    bus.we = 1'b0;
    bus.be = 4'h0;
    bus.wdata = '0;

    vecs[0]  = '{OFF_STATUS,   1, 4'hF, 32'd5,         0, 0, 0, 0, 0,        8'h00};
    vecs[1]  = '{OFF_STATUS,   1, 4'hF, 32'd123456789, 0, 1, 0, 0, 0,        8'h00};
    vecs[2]  = '{OFF_STATUS,   1, 4'hF, 32'd5,         0, 1, 0, 0, 0,        8'h00};
    vecs[3]  = '{OFF_STATUS,   0, 4'hF, 32'd0,         0, 1, 0, 0, 0,        8'h00};
    vecs[4]  = '{OFF_EXIT,     1, 4'h0, 32'h2A,        0, 1, 0, 1, 32'h2A,   8'h00};
    vecs[5]  = '{OFF_EXIT,     1, 4'hF, 32'h0,         0, 1, 0, 1, 32'h0,    8'h00};
    vecs[6]  = '{OFF_PRINT,    1, 4'hE, 32'h41,        0, 1, 0, 1, 32'h0,    8'h00};
    vecs[7]  = '{OFF_FIFOSTAT, 0, 4'hF, 32'h0,         0, 1, 0, 1, 32'h0,    8'h00};
    vecs[8]  = '{OFF_PRINT,    1, 4'h1, 32'h141,       0, 1, 0, 1, 32'h0,    8'h41};
    vecs[9]  = '{OFF_FIFOSTAT, 0, 4'hF, 32'h0,         1, 1, 0, 1, 32'h0,    8'h41};
    vecs[10] = '{OFF_CYCLES,   1, 4'hF, 32'hFFFF,      0, 1, 0, 1, 32'h0,    8'h41};
    vecs[11] = '{5'h14,        0, 4'hF, 32'h0,         0, 1, 0, 1, 32'h0,    8'h41};
    vecs[12] = '{OFF_EXIT,     0, 4'hF, 32'h0,         0, 1, 0, 1, 32'h0,    8'h41};
    vecs[13] = '{OFF_STATUS,   1, 4'hF, 32'd1,         0, 1, 1, 1, 32'h0,    8'h41};
    vecs[14] = '{OFF_PRINT,    0, 4'hF, 32'h0,         0, 1, 1, 1, 32'h0,    8'h41};
    vecs[15] = '{OFF_FIFOSTAT, 0, 4'hF, 32'h0,         1, 1, 1, 1, 32'h0,    8'h41};

    #3;
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_cvalid", 32'(char_valid_o), 32'd0);
    chk("rst_pass", 32'(tests_passed_o), 32'd0);
    chk("rst_exitval", exit_value_o, 32'd0);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      bus_txn(BASE | 32'(vecs[i].off), vecs[i].we, vecs[i].be,
              vecs[i].wdata, rd);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_pass", i), 32'(tests_passed_o),
          32'(vecs[i].exp_pass));
      chk($sformatf("v%0d_fail", i), 32'(tests_failed_o),
          32'(vecs[i].exp_fail));
      chk($sformatf("v%0d_exit", i), 32'(exit_valid_o),
          32'(vecs[i].exp_exit));
      chk($sformatf("v%0d_exitval", i), exit_value_o,
          vecs[i].exp_exit_val);
      chk($sformatf("v%0d_char", i), 32'(char_o),
          32'(vecs[i].exp_char));
      chk($sformatf("v%0d_cvalid", i), 32'(char_valid_o),
          32'(vecs[i].exp_char != 8'h00));
    end

    // Effects land with rvalid, not in the grant cycle.
    do_reset();
    bus.req = 1'b1;
    bus.addr = BASE | 32'(OFF_STATUS);
    bus.we = 1'b1;
    bus.be = 4'hF;
    bus.wdata = TEST_PASS_MAGIC;
    #1;
    chk("grant_cycle_pass", 32'(tests_passed_o), 32'd0);
    @(negedge clk_i);
    bus.req = 1'b0;
    chk("after_grant_pass", 32'(tests_passed_o), 32'd1);
    chk("after_grant_rvalid", 32'(bus.rvalid), 32'd1);
    @(negedge clk_i);
    chk("rvalid_single", 32'(bus.rvalid), 32'd0);

    // Two characters streaming out with the consumer ready.
    do_reset();
    char_ready_i = 1'b1;
    bus_txn(BASE | 32'(OFF_PRINT), 1, 4'h1, 32'h48, rd);
    chk("print_c0", 32'(char_o), 32'h48);
    bus_txn(BASE | 32'(OFF_PRINT), 1, 4'h1, 32'h69, rd);
    chk("print_c1", 32'(char_o), 32'h69);
    chk("print_v1", 32'(char_valid_o), 32'd1);
    @(negedge clk_i);
    chk("print_empty", 32'(char_valid_o), 32'd0);
    char_ready_i = 1'b0;

    // Fill the FIFO, stall the ninth PRINT, then free a slot.
    do_reset();
    for (int i = 0; i < 8; i++)
      bus_txn(BASE | 32'(OFF_PRINT), 1, 4'h1, 32'h30 + 32'(i), rd);
    bus.req = 1'b1;
    bus.addr = BASE | 32'(OFF_PRINT);
    bus.we = 1'b1;
    bus.be = 4'h1;
    bus.wdata = 32'h38;
    #1;
    chk("full_gnt0", 32'(bus.gnt), 32'd0);
    @(negedge clk_i);
    #1;
    chk("full_gnt0_hold", 32'(bus.gnt), 32'd0);
    bus.req = 1'b0;
    @(negedge clk_i);
    bus_txn(BASE | 32'(OFF_FIFOSTAT), 0, 4'hF, 32'h0, rd);
    chk("full_stat", rd, 32'h8000_0008);
    chk("full_head", 32'(char_o), 32'h30);
    bus.req = 1'b1;
    bus.addr = BASE | 32'(OFF_PRINT);
    bus.we = 1'b1;
    bus.wdata = 32'h38;
    char_ready_i = 1'b1;
    #1;
    chk("pop_same_cycle_gnt", 32'(bus.gnt), 32'd0);
    @(negedge clk_i);
    char_ready_i = 1'b0;
    #1;
    chk("freed_gnt", 32'(bus.gnt), 32'd1);
    chk("freed_head", 32'(char_o), 32'h31);
    @(negedge clk_i);
    bus.req = 1'b0;
    chk("freed_rvalid", 32'(bus.rvalid), 32'd1);
    bus_txn(BASE | 32'(OFF_FIFOSTAT), 0, 4'hF, 32'h0, rd);
    chk("refull_stat", rd, 32'h8000_0008);

    // Cycle counter spacing and wrap.
    do_reset();
    bus_txn(BASE | 32'(OFF_CYCLES), 0, 4'hF, 32'h0, c1);
    repeat (9) @(negedge clk_i);
    bus_txn(BASE | 32'(OFF_CYCLES), 0, 4'hF, 32'h0, c2);
    chk("cycles_delta", c2 - c1, 32'd10);
    force dut.r_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycles;
    repeat (3) @(negedge clk_i);
    bus_txn(BASE | 32'(OFF_CYCLES), 0, 4'hF, 32'h0, rd);
    chk("cycles_wrap", rd, 32'd1);

    // Reset mid-stream with characters queued and rvalid pending.
    do_reset();
    for (int i = 0; i < 3; i++)
      bus_txn(BASE | 32'(OFF_PRINT), 1, 4'h1, 32'h61 + 32'(i), rd);
    bus_txn(BASE | 32'(OFF_STATUS), 1, 4'hF, TEST_PASS_MAGIC, rd);
    bus_txn(BASE | 32'(OFF_EXIT), 1, 4'hF, 32'h7, rd);
    bus.req = 1'b1;
    bus.addr = BASE | 32'(OFF_FIFOSTAT);
    bus.we = 1'b0;
    @(posedge clk_i);
    #1;
    chk("pend_rvalid", 32'(bus.rvalid), 32'd1);
    chk("pend_rdata", bus.rdata, 32'd3);
    bus.req = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("arst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("arst_rdata", bus.rdata, 32'd0);
    chk("arst_cvalid", 32'(char_valid_o), 32'd0);
    chk("arst_char", 32'(char_o), 32'd0);
    chk("arst_pass", 32'(tests_passed_o), 32'd0);
    chk("arst_fail", 32'(tests_failed_o), 32'd0);
    chk("arst_exit", 32'(exit_valid_o), 32'd0);
    chk("arst_exitval", exit_value_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
    bus_txn(BASE | 32'(OFF_FIFOSTAT), 0, 4'hF, 32'h0, rd);
    chk("post_rst_stat", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
